// File: rtl/rc4_ksa.sv
// RC4 key-scheduling engine: fills S with the identity, then runs the KSA swap
// loop over a single-port S-RAM with one-cycle read latency.
module rc4_ksa #(
  parameter int unsigned KEY_LENGTH = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [8*KEY_LENGTH-1:0]   key,
  input  logic [7:0]                q,
  output logic [7:0]                address,
  output logic [7:0]                data,
  output logic                      wren,
  output logic                      done
);

  localparam int unsigned KW  = 8 * KEY_LENGTH;
  localparam int unsigned KIW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT_WR,
    SH_RD_I,
    SH_CAP_I,
    SH_RD_J,
    SH_CAP_J,
    SH_WR_I,
    SH_WR_J,
    SH_NEXT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      i_q, i_d;
  logic [7:0]      j_q, j_d;
  logic [7:0]      si_q, si_d;
  logic [7:0]      sj_q, sj_d;
  logic [KIW-1:0]  kidx_q, kidx_d;
  logic [KW-1:0]   key_q, key_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            wren_q, wren_d;
  logic            done_q, done_d;
  logic [7:0]      key_byte;

  // Select key byte kidx_q; byte 0 sits in the most significant position.
  always_comb begin
    key_byte = '0;
    for (int unsigned k = 0; k < KEY_LENGTH; k++) begin
      if (kidx_q == KIW'(k)) key_byte = key_q[8*(KEY_LENGTH-1-k) +: 8];
    end
  end

  // Next-state and datapath updates, then registered-output decode of the next state.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    addr_d  = '0;
    data_d  = '0;
    wren_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          state_d = INIT_WR;
        end
      end
      INIT_WR: begin
        if (i_q == 8'd255) begin
          i_d     = '0;
          kidx_d  = '0;
          state_d = SH_RD_I;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      SH_RD_I:  state_d = SH_CAP_I;
      SH_CAP_I: begin
        si_d    = q;
        j_d     = j_q + q + key_byte;
        state_d = SH_RD_J;
      end
      SH_RD_J:  state_d = SH_CAP_J;
      SH_CAP_J: begin
        sj_d    = q;
        state_d = SH_WR_I;
      end
      SH_WR_I:  state_d = SH_WR_J;
      SH_WR_J:  state_d = SH_NEXT;
      SH_NEXT: begin
        if (i_q == 8'd255) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIW'(KEY_LENGTH - 1)) ? '0 : kidx_q + KIW'(1);
          state_d = SH_RD_I;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      INIT_WR: begin
        addr_d = i_d;
        data_d = i_d;
        wren_d = 1'b1;
      end
      SH_RD_I, SH_CAP_I: addr_d = i_d;
      SH_RD_J, SH_CAP_J: addr_d = j_d;
      SH_WR_I: begin
        addr_d = i_d;
        data_d = sj_d;
        wren_d = 1'b1;
      end
      SH_WR_J: begin
        addr_d = j_d;
        data_d = si_d;
        wren_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
    end
  end

  assign address = addr_q;
  assign data    = data_q;
  assign wren    = wren_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rc4_ksa.sv
// Testbench for rc4_ksa: behavioural S-RAM, software KSA reference and write log.
module tb_rc4_ksa;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] key = '0;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        done;

  rc4_ksa #(.KEY_LENGTH(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .key     (key),
    .q       (q),
    .address (address),
    .data    (data),
    .wren    (wren),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Single-port RAM: address registered at the edge, q valid the following cycle.
  logic [7:0] mem [256];
  logic [7:0] ram_addr = '0;
  initial for (int k = 0; k < 256; k++) mem[k] = '0;
  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    ram_addr <= address;
  end
  assign q = mem[ram_addr];

  // Edge counter and write log (edge number, address, data).
  int         cyc = 0;
  int         w_edge[$];
  logic [7:0] w_addr[$];
  logic [7:0] w_data[$];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (wren) begin
      w_edge.push_back(cyc);
      w_addr.push_back(address);
      w_data.push_back(data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference KSA written directly from the algorithm.
  int ref_s[256];
  task automatic model_ksa(input logic [23:0] k, output int same_cnt);
    int j, t, kb;
    for (int i = 0; i < 256; i++) ref_s[i] = i;
    j = 0;
    same_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      kb = int'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
      j = (j + ref_s[i] + kb) % 256;
      if (i == j) same_cnt++;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  // One full run with all result checks; hold keeps start high through DONE,
  // scramble changes the key input mid-run.
  task automatic run_ksa(input logic [23:0] k, input bit hold, input bit scramble,
                         input int exp_lat, input int exp_writes);
    int e, lat, bad, same_ref, same_dut;
    bit seen[256];
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    w_edge.delete(); w_addr.delete(); w_data.delete();
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    if (!hold) start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      if (scramble && n == 500) key = ~k;
      if (done) begin
        lat = n;
        break;
      end
    end
    check($sformatf("latency key=%06h", k), lat, exp_lat);
    check($sformatf("writes key=%06h", k), w_addr.size(), exp_writes);

    bad = 0;
    for (int x = 0; x < 256; x++) begin
      if (x >= w_addr.size()) bad++;
      else if (w_edge[x] != e + 1 + x || w_addr[x] != 8'(x) || w_data[x] != 8'(x)) bad++;
    end
    check($sformatf("init_seq_bad key=%06h", k), bad, 0);

    model_ksa(k, same_ref);
    bad = 0;
    for (int x = 0; x < 256; x++) if (int'(mem[x]) != ref_s[x]) bad++;
    check($sformatf("s_bytes_bad key=%06h", k), bad, 0);

    for (int x = 0; x < 256; x++) seen[x] = 1'b0;
    for (int x = 0; x < 256; x++) seen[mem[x]] = 1'b1;
    bad = 0;
    for (int x = 0; x < 256; x++) if (!seen[x]) bad++;
    check($sformatf("perm_missing key=%06h", k), bad, 0);

    if (w_addr.size() >= 768) begin
      same_dut = 0;
      for (int p = 0; p < 256; p++)
        if (w_addr[256 + 2*p] == w_addr[257 + 2*p]) same_dut++;
      if (same_ref != 0) $display("note: key %06h has %0d i==j iterations", k, same_ref);
      check($sformatf("i_eq_j_count key=%06h", k), same_dut, same_ref);
    end
  endtask

  typedef struct {
    logic [23:0] key;
    bit          hold;
    bit          scramble;
    int          exp_lat;
    int          exp_writes;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int nw;
    vecs[0] = '{key: 24'h00033C, hold: 1'b0, scramble: 1'b0, exp_lat: 2048, exp_writes: 768};
    vecs[1] = '{key: 24'hFFFFFF, hold: 1'b0, scramble: 1'b0, exp_lat: 2048, exp_writes: 768};
    vecs[2] = '{key: 24'h123456, hold: 1'b0, scramble: 1'b1, exp_lat: 2048, exp_writes: 768};
    vecs[3] = '{key: 24'(  $urandom), hold: 1'b0, scramble: 1'b0, exp_lat: 2048, exp_writes: 768};

    // Asynchronous reset mid-clock with start high.
    start = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("rst_address", int'(address), 0);
    check("rst_data", int'(data), 0);
    check("rst_wren", int'(wren), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    w_edge.delete(); w_addr.delete(); w_data.delete();
    repeat (10) @(negedge clk);
    check("idle_no_writes", w_addr.size(), 0);
    check("idle_done", int'(done), 0);

    // Table-driven runs.
    foreach (vecs[v])
      run_ksa(vecs[v].key, vecs[v].hold, vecs[v].scramble, vecs[v].exp_lat, vecs[v].exp_writes);

    // Reset during the shuffle at i=100, then a clean rerun.
    @(negedge clk);
    key = 24'hA5A5A5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (256 + 7*100 + 3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_address", int'(address), 0);
    check("midrst_data", int'(data), 0);
    check("midrst_wren", int'(wren), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_ksa(24'h000001, 1'b0, 1'b0, 2048, 768);

    // Handshake: start held through DONE, then dropped, then a second run.
    run_ksa(24'h0BEEF0, 1'b1, 1'b0, 2048, 768);
    nw = w_addr.size();
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", int'(done), 1);
    check("hold_no_writes", w_addr.size(), nw);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    check("drop_no_writes", w_addr.size(), nw);
    run_ksa(24'hC0FFEE, 1'b0, 1'b1, 2048, 768);

    // Random keys.
    for (int r = 0; r < 3; r++) run_ksa(24'($urandom), 1'b0, 1'b0, 2048, 768);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_ksa.md
Name: rc4_ksa

Overview:
- RC4 key-scheduling engine for the Lab 4 decryption datapath.
- Builds the 256-byte S permutation in the shared S-RAM.
  - Init phase: S[i] = i.
  - Shuffle phase: standard KSA, j = j + S[i] + key[i mod KEY_LENGTH], then swap S[i] and S[j].
- It is the writer of S; the downstream PRGA/decrypt block reads S only after this block reports done.
- It is sole master of the S-RAM port while not in IDLE or DONE.

Parameters:
- KEY_LENGTH, 3: number of secret-key bytes. The key port width is 8*KEY_LENGTH.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level request, sampled only in IDLE.
- key  in  8*KEY_LENGTH  secret key. Byte 0 = most significant byte, so key[23:16] is byte 0 when KEY_LENGTH=3.
- q  in  8  S-RAM read data.
- address  out  8  S-RAM address.
- data  out  8  S-RAM write data.
- wren  out  1  S-RAM write enable.
- done  out  1  S fully scheduled; level signal.

Behaviour:
- Reset (async, reset_n=0):
  - State forced to IDLE; i, j, si, sj, key_reg cleared.
  - address=0, data=0, wren=0, done=0 immediately.
  - Reset mid-operation abandons the run. S-RAM contents are then partial, and the next start reruns both phases from scratch.
- RAM timing contract:
  - Address is registered by the RAM at the rising edge.
  - q is valid during the next cycle and is sampled at the end of that cycle (one-cycle read latency).
  - A write occurs at the edge ending any cycle with wren=1.
- Outputs address/data/wren/done are decoded from state and datapath registers only (Moore). No combinational path from q or start.
- States and transitions:
  - IDLE: wren=0, done=0. If start=1: key_reg<=key, i<=0, j<=0, go to INIT_WR.
  - INIT_WR: address=i, data=i, wren=1.
    - If i==255: i<=0, go to SH_RD_I.
    - Else i<=i+1.
    - Exactly 256 cycles.
  - SH_RD_I: address=i, wren=0.
  - SH_CAP_I: address=i. si<=q; j<=j+q+key_byte(i mod KEY_LENGTH), modulo 256 (8-bit wrap, carries discarded).
  - SH_RD_J: address=j, wren=0.
  - SH_CAP_J: address=j. sj<=q.
  - SH_WR_I: address=i, data=sj, wren=1.
  - SH_WR_J: address=j, data=si, wren=1.
  - SH_NEXT: wren=0.
    - If i==255: go to DONE.
    - Else i<=i+1, go to SH_RD_I.
  - DONE: done=1, wren=0, address=0.
    - Stays while start=1; goes to IDLE on first edge with start=0.
    - A new run requires start high again in IDLE.
- Shuffle costs 7 cycles per i, 1792 cycles total.
- Latency: if start is sampled at edge E, the last INIT write is at edge E+256 and done is high from edge E+2048.
- Write count per run: exactly 768 (256 init + 512 swap).
- Boundaries:
  - i==j: both swap writes hit the same address with equal values, so S is unchanged. This is legal; no special case.
  - i wraps only at the 255 checks above and never exceeds 255.
  - key_byte index = i mod KEY_LENGTH, computed with a modulo counter, not a divider. The counter resets to 0 at shuffle start and wraps at KEY_LENGTH-1.
  - Changes on key after start is sampled are ignored (key_reg is used).
  - start toggling outside IDLE/DONE is ignored.

Test Plan:
- Reset: assert reset_n=0 mid-clock with start=1 → address=0, data=0, wren=0, done=0 with no clock edge required. Release with start=0 → stays IDLE, no writes.
- Init phase: start=1 at edge E → edges E+1..E+256 write address k with data k for k=0..255, in order, no gaps.
- Key 24'h00033C with a behavioural RAM model → done rises at edge E+2048, exactly 768 writes. Final S equals a software KSA model byte-for-byte and is a permutation of 0..255.
- Key 24'hFFFFFF → j wraps on many iterations. Final S matches the model. i==j iterations occur (e.g. i=0: j=0+0+255=255 ≠0; bench flags each i==j case) with S unchanged at that index.
- Reset mid-shuffle at i=100 → outputs 0 asynchronously. A new start (key 24'h000001) yields a full 2048-cycle run and S matching the model for 24'h000001.
- Handshake: hold start=1 after done → done stays 1, no writes. Drop start → IDLE next edge, done=0. Raise again with a different key → second run correct. Change key during the run → no effect on result.
